priority_arbiter_ctrl: RTL and testbench
========================================

Name: priority_arbiter_ctrl

Overview:
Sequential arbiter that shares one resource among NUM_REQ requesters. It selects a winner with MSB-first priority, or with rotating priority when rr_mode=1. It holds that grant until the owner signals done, drops its request, or exceeds a hold-time limit. It sits in front of the shared datapath: it sequences who owns the resource and reports the owner as a one-hot vector and an encoded index.

Parameters:
NUM_REQ, 8, number of requesters (power of 2, 2..16)
ID_W, $clog2(NUM_REQ), width of the encoded grant index
MAX_HOLD, 16, maximum cycles one grant may last before forced release; 0 = unlimited
CNT_W, 5, width of hold counter; must hold MAX_HOLD

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  request vector, bit i = requester i, level-sensitive
done  input  1  owner finished, sampled only in GRANT state
rr_mode  input  1  0 = fixed priority (bit NUM_REQ-1 highest), 1 = round-robin; sampled only in IDLE
grant  output  NUM_REQ  one-hot grant, all zeros when no grant
grant_id  output  ID_W  index of granted requester, 0 when no grant
grant_valid  output  1  high while a grant is held
timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD
busy  output  1  high in GRANT and in RELEASE state

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low: rst_n low forces every register immediately, independent of clk.
- All outputs are registered.
- Reset values: state=IDLE, grant=0, grant_id=0, grant_valid=0, timeout=0, busy=0, hold_cnt=0, last_id=0.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req!=0 at a rising edge, the winner is computed combinationally from req, rr_mode and last_id.
  - At that edge: state<=GRANT, grant<=one-hot(winner), grant_id<=winner, grant_valid<=1, busy<=1, last_id<=winner, hold_cnt<=1.
  - Latency: grant is visible one cycle after req is sampled.
  - If req==0, stay in IDLE.
- Winner selection:
  - Fixed mode: highest set index of req.
  - Round-robin mode: search order is last_id-1, last_id-2, ..., 0, NUM_REQ-1, ..., last_id (wrap-around); the first set bit wins.
  - After reset, last_id=0, so the round-robin search order is NUM_REQ-1 down to 0, identical to fixed mode.
  - The last owner is lowest priority and is regranted only if it is the sole requester.
- GRANT:
  - Exit when done=1 OR req[grant_id]=0 OR (MAX_HOLD!=0 AND hold_cnt==MAX_HOLD).
  - On exit: grant<=0, grant_id<=0, grant_valid<=0, state<=RELEASE.
  - timeout<=1 only when the exit is caused solely by the hold limit (done=0 and request still high). If done coincides with the limit, done wins and timeout stays 0.
  - Otherwise stay in GRANT with hold_cnt<=hold_cnt+1, saturating at MAX_HOLD.
  - Changes to other req bits during GRANT are ignored; there is no preemption.
- RELEASE:
  - Exactly one dead cycle with busy=1 and grant=0, which guarantees a gap between owners.
  - Next state is IDLE; timeout<=0.
  - Minimum back-to-back grant spacing: 2 cycles of grant_valid=0 (RELEASE cycle plus IDLE arbitration cycle).
- A grant always lasts at least 1 cycle. done asserted in the first GRANT cycle ends the grant after exactly 1 cycle.
- rr_mode changes outside IDLE take effect at the next arbitration.
- Reset asserted mid-grant clears the grant asynchronously. The first arbitration after reset again uses last_id=0.
- Invariants: grant is one-hot or zero; grant_valid == (grant!=0); grant[grant_id]==1 whenever grant_valid=1.

Test Plan:
- Reset then idle: rst_n=0 with req=8'hFF -> all outputs 0. Release rst_n, req=0 for 5 cycles -> grant_valid stays 0, busy=0.
- Fixed priority: rr_mode=0, req=8'b0010_0100 -> one cycle later grant=8'b0010_0000, grant_id=5. Pulse done -> grant=0 next cycle; busy=1 for one cycle; then grant_id=5 again while req is unchanged.
- Round-robin rotation: rr_mode=1, req=8'hFF held, done pulsed in each grant -> grant_id sequence 7,6,5,4,3,2,1,0,7. Each grant is separated by 2 cycles of grant_valid=0.
- Round-robin sole requester: after owner 3, req=8'b0000_1000 only -> grant_id=3 is regranted.
- Timeout: MAX_HOLD=16, req=8'h01 held, done=0 -> grant_valid high for exactly 16 cycles, then timeout=1 for 1 cycle with grant=0. Repeat with done=1 on cycle 16 -> timeout stays 0.
- Request drop and mid-grant reset: owner 6 deasserts req[6] at cycle 3 -> grant cleared next edge. Separately, rst_n pulsed low mid-grant -> grant, grant_valid and busy go to 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/priority_arbiter_ctrl.sv
// Grant sequencer for one shared resource: MSB-first or rotating priority,
// grant held until done / request drop / hold limit, then one dead cycle.
module priority_arbiter_ctrl #(
    parameter int NUM_REQ  = 8,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    input  logic               rr_mode,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid,
    output logic               timeout,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam bit                 HOLD_EN  = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0]   HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0]   CNT_SAT  = HOLD_EN ? HOLD_LIM : {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0] REQ_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [ID_W-1:0]      r_grant_id;
    logic                 r_grant_valid;
    logic                 r_timeout;
    logic                 r_busy;
    logic [CNT_W-1:0]     r_hold_cnt;
    logic [ID_W-1:0]      r_last_id;

    state_t               w_nxt_state;
    logic [NUM_REQ-1:0]   w_nxt_grant;
    logic [ID_W-1:0]      w_nxt_grant_id;
    logic                 w_nxt_grant_valid;
    logic                 w_nxt_timeout;
    logic                 w_nxt_busy;
    logic [CNT_W-1:0]     w_nxt_hold_cnt;
    logic [ID_W-1:0]      w_nxt_last_id;

    logic [ID_W-1:0]      w_winner;
    logic [ID_W-1:0]      w_idx;
    logic                 w_found;
    logic                 w_limit;
    logic                 w_owner_req;
    logic                 w_exit;

    assign w_limit     = HOLD_EN && (r_hold_cnt == HOLD_LIM);
    assign w_owner_req = req[r_grant_id];
    assign w_exit      = done | ~w_owner_req | w_limit;

    // Winner search: fixed keeps the highest set index; round-robin walks down from last_id-1 with wrap.
    always_comb begin
        w_winner = {ID_W{1'b0}};
        w_idx    = {ID_W{1'b0}};
        w_found  = 1'b0;
        if (rr_mode) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                w_idx    = r_last_id - ID_W'(k);
                w_winner = (!w_found && req[w_idx]) ? w_idx : w_winner;
                w_found  = w_found | req[w_idx];
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_winner = req[i] ? ID_W'(i) : w_winner;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/GRANT/RELEASE sequencer.
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_grant       = r_grant;
        w_nxt_grant_id    = r_grant_id;
        w_nxt_grant_valid = r_grant_valid;
        w_nxt_timeout     = r_timeout;
        w_nxt_busy        = r_busy;
        w_nxt_hold_cnt    = r_hold_cnt;
        w_nxt_last_id     = r_last_id;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_nxt_state       = ST_GRANT;
                    w_nxt_grant       = REQ_ONE << w_winner;
                    w_nxt_grant_id    = w_winner;
                    w_nxt_grant_valid = 1'b1;
                    w_nxt_busy        = 1'b1;
                    w_nxt_last_id     = w_winner;
                    w_nxt_hold_cnt    = CNT_ONE;
                end else begin
                    w_nxt_state       = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (w_exit) begin
                    w_nxt_state       = ST_RELEASE;
                    w_nxt_grant       = {NUM_REQ{1'b0}};
                    w_nxt_grant_id    = {ID_W{1'b0}};
                    w_nxt_grant_valid = 1'b0;
                    // done takes precedence: only a pure hold-limit exit counts as a timeout
                    w_nxt_timeout     = w_limit & ~done & w_owner_req;
                end else begin
                    w_nxt_hold_cnt    = (r_hold_cnt == CNT_SAT) ? r_hold_cnt : r_hold_cnt + CNT_ONE;
                end
            end
            ST_RELEASE: begin
                w_nxt_state   = ST_IDLE;
                w_nxt_timeout = 1'b0;
                w_nxt_busy    = 1'b0;
            end
            default: begin
                w_nxt_state       = ST_IDLE;
                w_nxt_grant       = {NUM_REQ{1'b0}};
                w_nxt_grant_id    = {ID_W{1'b0}};
                w_nxt_grant_valid = 1'b0;
                w_nxt_timeout     = 1'b0;
                w_nxt_busy        = 1'b0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= {NUM_REQ{1'b0}};
            r_grant_id    <= {ID_W{1'b0}};
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b0;
            r_hold_cnt    <= {CNT_W{1'b0}};
            r_last_id     <= {ID_W{1'b0}};
        end else begin
            r_state       <= w_nxt_state;
            r_grant       <= w_nxt_grant;
            r_grant_id    <= w_nxt_grant_id;
            r_grant_valid <= w_nxt_grant_valid;
            r_timeout     <= w_nxt_timeout;
            r_busy        <= w_nxt_busy;
            r_hold_cnt    <= w_nxt_hold_cnt;
            r_last_id     <= w_nxt_last_id;
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;
    assign busy        = r_busy;

endmodule

// File: tb/tb_priority_arbiter_ctrl.sv
// Bench for priority_arbiter_ctrl: vector table, directed corner sequences,
// and random traffic against an owner/cooldown reference model.
module tb_priority_arbiter_ctrl;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int MH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = 8'hFF;
    logic          done = 1'b0;
    logic          rr_mode = 1'b0;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_id;
    logic          grant_valid;
    logic          timeout;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: current owner (-1 none), cycles held, cooldown flag, last owner
    int m_owner;
    int m_held;
    int m_last;
    bit m_gap;
    bit m_to;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
        logic       b;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    priority_arbiter_ctrl #(.NUM_REQ(N), .MAX_HOLD(MH), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .rr_mode(rr_mode),
        .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid),
        .timeout(timeout), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [7:0] r, input bit rr, input int last);
        if (!rr) begin
            for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (last - k + N) % N;
                if (r[idx]) return idx;
            end
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_owner = -1; m_held = 0; m_last = 0; m_gap = 1'b0; m_to = 1'b0;
    endtask

    task automatic m_step();
        if (m_owner >= 0) begin
            if (done || !req[m_owner] || m_held == MH) begin
                m_to    = !done && req[m_owner];
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
            m_to  = 1'b0;
        end else if (req != 8'h00) begin
            m_owner = pick(req, rr_mode, m_last);
            m_last  = m_owner;
            m_held  = 1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 8'h00; done = 1'b0; rr_mode = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(output int gap);
        gap = 0;
        while (!grant_valid && gap < 12) begin
            gap++;
            cyc();
        end
        chk("grant_wait", {31'd0, grant_valid}, 32'd1);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        cyc();
        done = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int n;
        int rr_ids[9];
        logic [13:0] exp_v;

        tbl[0] = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b1};
        tbl[1] = '{8'h24, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[2] = '{8'h24, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[3] = '{8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b1};
        tbl[4] = '{8'h04, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[5] = '{8'h04, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[6] = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b1};
        tbl[7] = '{8'h04, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[8] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[9] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        rr_ids = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

        // reset held with all requests up
        #12;
        chk("rst_outputs", {18'd0, grant, grant_id, grant_valid, timeout, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h00;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("idle_quiet", {30'd0, grant_valid, busy}, 32'd0);
        end

        // fixed-priority vector table
        for (int i = 0; i < 10; i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            cyc();
            chk("tbl_grant", {24'd0, grant}, {24'd0, tbl[i].g});
            chk("tbl_id",    {29'd0, grant_id}, {29'd0, tbl[i].id});
            chk("tbl_vbt",   {29'd0, grant_valid, busy, timeout}, {29'd0, tbl[i].v, tbl[i].b, 1'b0});
        end
        done = 1'b0;

        // round-robin rotation with all requesters active
        do_reset();
        rr_mode = 1'b1;
        req     = 8'hFF;
        for (int j = 0; j < 9; j++) begin
            wait_grant(gap);
            chk("rr_id", {29'd0, grant_id}, rr_ids[j]);
            chk("rr_onehot", {24'd0, grant}, 32'd1 << rr_ids[j]);
            if (j > 0) chk("rr_gap", gap, 32'd2);
            pulse_done();
        end
        // sole requester is regranted even though it was last owner
        req = 8'h08;
        wait_grant(gap);
        chk("rr_after7", {29'd0, grant_id}, 32'd3);
        pulse_done();
        wait_grant(gap);
        chk("rr_sole", {29'd0, grant_id}, 32'd3);
        pulse_done();
        req = 8'h00;

        // hold limit forces release with a one-cycle timeout pulse
        do_reset();
        req = 8'h01;
        wait_grant(gap);
        n = 0;
        while (grant_valid && n < 40) begin
            n++;
            cyc();
        end
        chk("hold_len", n, 32'd16);
        chk("to_set", {29'd0, timeout, busy, grant_valid}, 32'b110);
        chk("to_grant", {24'd0, grant}, 32'd0);
        cyc();
        chk("to_pulse", {31'd0, timeout}, 32'd0);
        wait_grant(gap);
        n = 1;
        while (n < 16) begin
            cyc();
            n++;
        end
        chk("hold_valid16", {31'd0, grant_valid}, 32'd1);
        pulse_done();
        chk("done_at_limit", {29'd0, timeout, busy, grant_valid}, 32'b010);

        // owner drops its request on its third cycle
        do_reset();
        req = 8'h40;
        wait_grant(gap);
        chk("drop_id", {29'd0, grant_id}, 32'd6);
        cyc();
        cyc();
        chk("drop_held", {31'd0, grant_valid}, 32'd1);
        req = 8'h00;
        cyc();
        chk("drop_clear", {23'd0, grant, grant_valid}, 32'd0);

        // asynchronous reset in the middle of a grant
        req = 8'h40;
        wait_grant(gap);
        chk("mid_id", {29'd0, grant_id}, 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst", {22'd0, grant, grant_valid, busy}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        rr_mode = 1'b1;
        req     = 8'hFF;
        wait_grant(gap);
        chk("rst_last_id", {29'd0, grant_id}, 32'd7);

        // random traffic against the reference model
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       req = 8'h00;
                    1:       req = 8'($urandom);
                    default: req = 8'($urandom) & 8'($urandom);
                endcase
            end
            done    = ($urandom_range(0, 11) == 0);
            rr_mode = 1'($urandom_range(0, 1));
            cyc();
            m_step();
            exp_v = {(m_owner >= 0) ? 8'(1 << m_owner) : 8'h00,
                     (m_owner >= 0) ? 3'(m_owner) : 3'd0,
                     (m_owner >= 0), (m_owner >= 0) || m_gap, m_to};
            chk("random", {18'd0, grant, grant_id, grant_valid, busy, timeout}, {18'd0, exp_v});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
